// File: rtl/initial_try9.sv
// UART receiver that gathers four 8N1 bytes, then replays them on a UART transmitter.
// Latency: done about 9.5 bit times after the start edge; busy rises the cycle after ready.
// Backpressure: none on the serial line; start edges are ignored while the transmitter is busy.
module initial_try9 #(
  parameter int CLKS_PER_BIT = 1250
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        data,
  output logic        tx,
  output logic [9:0]  data_store,
  output logic [7:0]  bit_count,
  output logic [1:0]  state,
  output logic        busy,
  output logic        idle,
  output logic        done,
  output logic        signal,
  output logic        ready,
  output logic [3:0]  bit_count3,
  output logic [31:0] data_store2
);

  // The bit timer must be able to hold CLKS_PER_BIT - 1.
  localparam int TW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_START = 2'b01,
    ST_DATA  = 2'b10,
    ST_STOP  = 2'b11
  } rx_state_t;

  rx_state_t       rx_q;
  rx_state_t       rx_d;
  logic            sync_meta;
  logic            sig_prev;
  logic            sig_fall;
  logic [TW-1:0]   rx_timer;
  logic [2:0]      rx_bit;
  logic [7:0]      rx_shift;
  logic [2:0]      rx_cnt;
  logic            timer_clr;
  logic            shift_en;
  logic            bit_inc;
  logic            frame_ok;
  logic [TW-1:0]   tx_timer;
  logic [1:0]      tx_byte;
  logic [7:0]      tx_cur;
  logic [2:0]      tx_data_idx;

  assign state    = rx_q;
  assign sig_fall = sig_prev & ~signal;
  assign idle     = (rx_q == ST_IDLE) && !busy;

  // Two-flop synchronizer on the RX line plus one more flop for falling-edge detection.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync_meta <= 1'b1;
      signal    <= 1'b1;
      sig_prev  <= 1'b1;
    end else begin
      sync_meta <= data;
      signal    <= sync_meta;
      sig_prev  <= signal;
    end
  end

  // RX state register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rx_q <= ST_IDLE;
    end else begin
      rx_q <= rx_d;
    end
  end

  // RX next state and datapath strobes: START samples mid-bit, DATA/STOP one bit later each.
  always_comb begin
    rx_d      = rx_q;
    timer_clr = 1'b0;
    shift_en  = 1'b0;
    bit_inc   = 1'b0;
    frame_ok  = 1'b0;
    case (rx_q)
      ST_IDLE: begin
        // ready is gated too so a start edge cannot slip in the cycle before busy rises.
        if (!busy && !ready && sig_fall) begin
          rx_d      = ST_START;
          timer_clr = 1'b1;
        end
      end
      ST_START: begin
        if (rx_timer == HALF_LAST) begin
          timer_clr = 1'b1;
          rx_d      = signal ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (rx_timer == BIT_LAST) begin
          timer_clr = 1'b1;
          shift_en  = 1'b1;
          if (rx_bit == 3'd7) begin
            rx_d = ST_STOP;
          end else begin
            bit_inc = 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (rx_timer == BIT_LAST) begin
          timer_clr = 1'b1;
          rx_d      = ST_IDLE;
          frame_ok  = signal;
        end
      end
      default: rx_d = ST_IDLE;
    endcase
  end

  // RX bit timer, data-bit index and LSB-first shift register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rx_timer <= '0;
      rx_bit   <= 3'd0;
      rx_shift <= 8'd0;
    end else begin
      if (timer_clr || rx_q == ST_IDLE) begin
        rx_timer <= '0;
      end else begin
        rx_timer <= rx_timer + TW'(1);
      end
      if (rx_q != ST_DATA) begin
        rx_bit <= 3'd0;
      end else if (bit_inc) begin
        rx_bit <= rx_bit + 3'd1;
      end
      if (shift_en) begin
        rx_shift <= {signal, rx_shift[7:1]};
      end
    end
  end

  // Commit a good frame: store it, shift it into the 4-byte buffer, pulse done and ready.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      data_store  <= 10'd0;
      data_store2 <= 32'd0;
      bit_count   <= 8'd0;
      rx_cnt      <= 3'd0;
      done        <= 1'b0;
      ready       <= 1'b0;
    end else begin
      done  <= frame_ok;
      ready <= frame_ok && (rx_cnt == 3'd3);
      if (frame_ok) begin
        data_store  <= {1'b1, rx_shift, 1'b0};
        data_store2 <= {rx_shift, data_store2[31:8]};
        bit_count   <= bit_count + 8'd1;
        rx_cnt      <= (rx_cnt == 3'd3) ? 3'd0 : rx_cnt + 3'd1;
      end
    end
  end

  // TX sequencer: 4 bytes x 10 bits x CLKS_PER_BIT clocks, started by ready.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      busy       <= 1'b0;
      tx_timer   <= '0;
      tx_byte    <= 2'd0;
      bit_count3 <= 4'd0;
    end else if (!busy) begin
      tx_timer   <= '0;
      tx_byte    <= 2'd0;
      bit_count3 <= 4'd0;
      if (ready) begin
        busy <= 1'b1;
      end
    end else if (tx_timer == BIT_LAST) begin
      tx_timer <= '0;
      if (bit_count3 == 4'd9) begin
        bit_count3 <= 4'd0;
        if (tx_byte == 2'd3) begin
          busy <= 1'b0;
        end else begin
          tx_byte <= tx_byte + 2'd1;
        end
      end else begin
        bit_count3 <= bit_count3 + 4'd1;
      end
    end else begin
      tx_timer <= tx_timer + TW'(1);
    end
  end

  // Select the buffer byte currently being sent; the buffer is frozen while busy.
  always_comb begin
    tx_cur = 8'd0;
    case (tx_byte)
      2'd0:    tx_cur = data_store2[7:0];
      2'd1:    tx_cur = data_store2[15:8];
      2'd2:    tx_cur = data_store2[23:16];
      default: tx_cur = data_store2[31:24];
    endcase
  end

  // TX line: start bit 0, data LSB first, stop bit and idle high.
  always_comb begin
    tx          = 1'b1;
    tx_data_idx = 3'(bit_count3 - 4'd1);
    if (busy) begin
      if (bit_count3 == 4'd0) begin
        tx = 1'b0;
      end else if (bit_count3 <= 4'd8) begin
        tx = tx_cur[tx_data_idx];
      end
    end
  end

endmodule

// File: tb/tb_initial_try9.sv
// Directed bench for initial_try9 with a short bit period.
// Drives the RX line at negedges and samples outputs at negedges.
// Monitors count done/ready pulses, START visits and busy run length.
module tb_initial_try9;

  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        nrst;
  logic        data;
  logic        tx;
  logic [9:0]  data_store;
  logic [7:0]  bit_count;
  logic [1:0]  state;
  logic        busy;
  logic        idle;
  logic        done;
  logic        signal;
  logic        ready;
  logic [3:0]  bit_count3;
  logic [31:0] data_store2;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int frame_start_cyc = 0;
  int done_cnt = 0;
  int last_done_cyc = 0;
  int ready_cnt = 0;
  int ready_orphan = 0;
  int start_seen = 0;
  int busy_run = 0;
  int busy_len = 0;
  int d0;
  int s0;

  initial_try9 #(.CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .nrst        (nrst),
    .data        (data),
    .tx          (tx),
    .data_store  (data_store),
    .bit_count   (bit_count),
    .state       (state),
    .busy        (busy),
    .idle        (idle),
    .done        (done),
    .signal      (signal),
    .ready       (ready),
    .bit_count3  (bit_count3),
    .data_store2 (data_store2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done) begin
      done_cnt      = done_cnt + 1;
      last_done_cyc = cyc;
    end
    if (ready) ready_cnt = ready_cnt + 1;
    if (ready && !done) ready_orphan = ready_orphan + 1;
    if (state == 2'b01) start_seen = start_seen + 1;
    if (busy) begin
      busy_run = busy_run + 1;
    end else if (busy_run != 0) begin
      busy_len = busy_run;
      busy_run = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    data = 1'b0;
    frame_start_cyc = cyc;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      data = b[i];
      repeat (CPB) @(negedge clk);
    end
    data = stop_bit;
    repeat (CPB) @(negedge clk);
    data = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic wait_busy(input logic lvl, input int limit, input string tag);
    int n;
    n = 0;
    while (busy !== lvl && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'b0, busy}, {31'b0, lvl});
  endtask

  task automatic tx_capture(input logic [31:0] exp_word);
    logic [9:0] fr;
    fr = 10'd0;
    wait_busy(1'b1, 20 * CPB, "tx_busy_rise");
    repeat (CPB / 2) @(negedge clk);
    for (int by = 0; by < 4; by++) begin
      for (int k = 0; k < 10; k++) begin
        check("tx_bit_count3", {28'b0, bit_count3}, k);
        fr[k] = tx;
        repeat (CPB) @(negedge clk);
      end
      check("tx_frame", {22'b0, fr}, {22'b0, 1'b1, exp_word[by*8 +: 8], 1'b0});
    end
  endtask

  initial begin
    nrst = 1'b0;
    data = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx",          {31'b0, tx},         32'd1);
    check("rst_data_store",  {22'b0, data_store}, 32'd0);
    check("rst_bit_count",   {24'b0, bit_count},  32'd0);
    check("rst_state",       {30'b0, state},      32'd0);
    check("rst_busy",        {31'b0, busy},       32'd0);
    check("rst_idle",        {31'b0, idle},       32'd1);
    check("rst_done",        {31'b0, done},       32'd0);
    check("rst_signal",      {31'b0, signal},     32'd1);
    check("rst_ready",       {31'b0, ready},      32'd0);
    check("rst_bit_count3",  {28'b0, bit_count3}, 32'd0);
    check("rst_data_store2", data_store2,         32'd0);
    nrst = 1'b1;
    repeat (4) @(negedge clk);

    // Single frame 0x53.
    send_byte(8'h53, 1'b1);
    check("f1_done_cnt",    done_cnt, 32'd1);
    check("f1_latency",     last_done_cyc - frame_start_cyc, 9 * CPB + CPB / 2 + 3);
    check("f1_data_store",  {22'b0, data_store}, 32'h2A6);
    check("f1_bit_count",   {24'b0, bit_count},  32'd1);
    check("f1_state",       {30'b0, state},      32'd0);
    check("f1_data_store2", data_store2,         32'h5300_0000);

    // Fill the buffer and check the replay on tx.
    send_byte(8'h6E, 1'b1);
    send_byte(8'h61, 1'b1);
    check("f3_ready_cnt", ready_cnt, 32'd0);
    fork
      send_byte(8'h70, 1'b1);
      tx_capture(32'h7061_6E53);
    join
    check("f4_data_store2", data_store2, 32'h7061_6E53);
    check("f4_ready_cnt",   ready_cnt,    32'd1);
    check("f4_ready_align", ready_orphan, 32'd0);
    check("f4_done_cnt",    done_cnt,     32'd4);
    check("f4_bit_count",   {24'b0, bit_count}, 32'd4);
    check("tx_busy_len",    busy_len, 40 * CPB);
    check("tx_idle_line",   {31'b0, tx},         32'd1);
    check("tx_idle_index",  {28'b0, bit_count3}, 32'd0);
    check("tx_idle_flag",   {31'b0, idle},       32'd1);

    // Short low glitch in IDLE.
    d0 = done_cnt;
    s0 = start_seen;
    @(negedge clk);
    data = 1'b0;
    repeat (4) @(negedge clk);
    data = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("gl_start_seen", {31'b0, (start_seen > s0)}, 32'd1);
    check("gl_state",      {30'b0, state},      32'd0);
    check("gl_done",       done_cnt - d0,       32'd0);
    check("gl_data_store", {22'b0, data_store}, 32'h2E0);

    // Framing error: stop bit low.
    d0 = done_cnt;
    send_byte(8'h3C, 1'b0);
    check("fe_done",        done_cnt - d0,       32'd0);
    check("fe_bit_count",   {24'b0, bit_count},  32'd4);
    check("fe_data_store",  {22'b0, data_store}, 32'h2E0);
    check("fe_data_store2", data_store2,         32'h7061_6E53);
    check("fe_state",       {30'b0, state},      32'd0);

    // Frame sent while the transmitter is busy.
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    wait_busy(1'b1, 2 * CPB, "bz_busy_high");
    d0 = done_cnt;
    send_byte(8'h99, 1'b1);
    check("bz_busy_still",  {31'b0, busy},      32'd1);
    check("bz_done",        done_cnt - d0,      32'd0);
    check("bz_data_store2", data_store2,        32'h4433_2211);
    check("bz_bit_count",   {24'b0, bit_count}, 32'd8);
    wait_busy(1'b0, 40 * CPB, "bz_busy_fall");
    repeat (2) @(negedge clk);
    send_byte(8'hA5, 1'b1);
    check("bz_next_data_store",  {22'b0, data_store}, 32'h34A);
    check("bz_next_data_store2", data_store2,         32'hA544_3322);
    check("bz_next_bit_count",   {24'b0, bit_count},  32'd9);

    // Reset in the middle of a transmission.
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1);
    wait_busy(1'b1, 4 * CPB, "mr_busy_high");
    repeat (3 * CPB) @(negedge clk);
    nrst = 1'b0;
    #1;
    check("mr_tx",          {31'b0, tx},         32'd1);
    check("mr_busy",        {31'b0, busy},       32'd0);
    check("mr_data_store2", data_store2,         32'd0);
    check("mr_bit_count3",  {28'b0, bit_count3}, 32'd0);
    check("mr_bit_count",   {24'b0, bit_count},  32'd0);
    check("mr_data_store",  {22'b0, data_store}, 32'd0);
    check("mr_idle",        {31'b0, idle},       32'd1);
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    repeat (4) @(negedge clk);
    d0 = done_cnt;
    send_byte(8'h5A, 1'b1);
    check("mr_next_done",        done_cnt - d0,       32'd1);
    check("mr_next_data_store",  {22'b0, data_store}, 32'h2B4);
    check("mr_next_data_store2", data_store2,         32'h5A00_0000);
    check("mr_next_bit_count",   {24'b0, bit_count},  32'd1);
    check("mr_next_busy",        {31'b0, busy},       32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
